// File: rtl/pc_target_pkg.sv
// Shared processor constants for the branch/jump target path.
package pc_target_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [1:0]  ALIGN_MASK   = 2'b00;

endpackage

// File: rtl/pc_target_reg.sv
// Capture register for the computed target; reset takes priority over capture.
module pc_target_reg #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture,
    input  logic [XLEN-1:0] targetD,
    output logic [XLEN-1:0] pcTargetQ,
    output logic            validQ
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcTargetQ <= '0;
            validQ    <= 1'b0;
        end else if (capture) begin
            pcTargetQ <= targetD;
            validQ    <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_target.sv
// Branch/JAL/JALR target adder with carry and alignment flags plus an optional registered copy.
module pc_target
    import pc_target_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] immExt,
    input  logic [XLEN-1:0] rs1,
    input  logic            jalrSel,
    input  logic            capture,
    output logic [XLEN-1:0] pcTarget,
    output logic            carry,
    output logic            misaligned,
    output logic [XLEN-1:0] pcTargetQ,
    output logic            validQ
);

    logic [XLEN-1:0] base;
    logic [XLEN:0]   sumWide;

    // Explicit mux keeps an undriven rs1 from leaking X when jalrSel is low.
    always_comb begin
        base = pc;
        if (jalrSel) begin
            base = rs1;
        end
    end

    assign sumWide  = {1'b0, base} + {1'b0, immExt};
    assign carry    = sumWide[XLEN];
    assign pcTarget = {sumWide[XLEN-1:1], sumWide[0] & ~jalrSel};

    generate
        if (ALIGN_CHECK) begin : gAlign
            assign misaligned = (pcTarget[1:0] != ALIGN_MASK);
        end else begin : gNoAlign
            assign misaligned = 1'b0;
        end
    endgenerate

    pc_target_reg #(
        .XLEN(XLEN)
    ) uReg (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture),
        .targetD  (pcTarget),
        .pcTargetQ(pcTargetQ),
        .validQ   (validQ)
    );

endmodule

// File: tb/tb_pc_target.sv
// Self-checking bench for pc_target: directed corner cases then randomized traffic against an arithmetic model.
module tb_pc_target;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] immExt;
    logic [31:0] rs1;
    logic        jalrSel;
    logic        capture;
    logic [31:0] pcTarget;
    logic        carry;
    logic        misaligned;
    logic [31:0] pcTargetQ;
    logic        validQ;

    int unsigned nChecks = 0;
    int unsigned nPassed = 0;

    // Reference state for the registered copy
    logic [31:0] mQ;
    logic        mValid;

    pc_target #(
        .XLEN(32),
        .ALIGN_CHECK(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .immExt    (immExt),
        .rs1       (rs1),
        .jalrSel   (jalrSel),
        .capture   (capture),
        .pcTarget  (pcTarget),
        .carry     (carry),
        .misaligned(misaligned),
        .pcTargetQ (pcTargetQ),
        .validQ    (validQ)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPassed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Model: plain 64-bit arithmetic on the selected base.
    function automatic logic [31:0] modelTarget(input logic [31:0] p, input logic [31:0] imm,
                                                input logic [31:0] r, input logic j);
        longint unsigned b, s, t;
        b = j ? longint'(r) : longint'(p);
        s = (b + longint'(imm)) % 64'h1_0000_0000;
        t = j ? (s - (s % 2)) : s;
        return t[31:0];
    endfunction

    function automatic logic modelCarry(input logic [31:0] p, input logic [31:0] imm,
                                        input logic [31:0] r, input logic j);
        longint unsigned b;
        b = j ? longint'(r) : longint'(p);
        return ((b + longint'(imm)) >= 64'h1_0000_0000);
    endfunction

    task automatic checkComb(input string tag);
        logic [31:0] t;
        t = modelTarget(pc, immExt, rs1, jalrSel);
        checkVal({tag, ".target"}, pcTarget, t);
        checkVal({tag, ".carry"}, {31'b0, carry}, {31'b0, modelCarry(pc, immExt, rs1, jalrSel)});
        checkVal({tag, ".misal"}, {31'b0, misaligned}, {31'b0, (t % 4) != 0});
    endtask

    task automatic clockEdge(input string tag);
        if (reset) begin
            mQ     = '0;
            mValid = 1'b0;
        end else if (capture) begin
            mQ     = modelTarget(pc, immExt, rs1, jalrSel);
            mValid = 1'b1;
        end
        @(posedge clk);
        #1;
        checkVal({tag, ".q"}, pcTargetQ, mQ);
        checkVal({tag, ".valid"}, {31'b0, validQ}, {31'b0, mValid});
    endtask

    task automatic directed(input string tag, input logic [31:0] p, input logic [31:0] imm,
                            input logic [31:0] r, input logic j,
                            input logic [31:0] expT, input logic expC, input logic expM);
        pc = p; immExt = imm; rs1 = r; jalrSel = j;
        #1;
        checkVal({tag, ".target"}, pcTarget, expT);
        checkVal({tag, ".carry"}, {31'b0, carry}, {31'b0, expC});
        checkVal({tag, ".misal"}, {31'b0, misaligned}, {31'b0, expM});
    endtask

    initial begin
        mQ = '0; mValid = 1'b0;
        reset = 1'b1; capture = 1'b0; pc = '0; immExt = '0; rs1 = '0; jalrSel = 1'b0;
        #2;
        clockEdge("reset");

        reset = 1'b0;
        @(negedge clk);
        directed("add4",   32'd4,        32'd4,        32'd0,      1'b0, 32'h0000_0008, 1'b0, 1'b0);
        directed("misal",  32'd12,       32'd10,       32'd0,      1'b0, 32'h0000_0016, 1'b0, 1'b1);
        directed("wrapUp", 32'hFFFF_FFFC, 32'd8,       32'd0,      1'b0, 32'h0000_0004, 1'b1, 1'b0);
        directed("wrapDn", 32'h0000_0100, 32'hFFFF_FFF0, 32'd0,    1'b0, 32'h0000_00F0, 1'b1, 1'b0);
        directed("jalr",   32'h0000_0000, 32'd2,       32'h1001,   1'b1, 32'h0000_1002, 1'b0, 1'b1);

        // Undriven rs1 must not disturb a non-JALR target
        pc = 32'h80; immExt = 32'h10; rs1 = 'x; jalrSel = 1'b0;
        #1;
        checkVal("noX", {31'b0, $isunknown(pcTarget)}, 32'd0);
        checkVal("noX.target", pcTarget, 32'h90);
        rs1 = '0;

        // Capture then hold
        @(negedge clk);
        pc = 32'h40; immExt = 32'h20; jalrSel = 1'b0; capture = 1'b1;
        clockEdge("cap");
        checkVal("cap.q.const", pcTargetQ, 32'h60);
        checkVal("cap.valid.const", {31'b0, validQ}, 32'd1);
        capture = 1'b0; pc = 32'h1234; immExt = 32'h8;
        clockEdge("hold");
        checkVal("hold.q.const", pcTargetQ, 32'h60);

        // Reset beats capture; combinational path keeps tracking
        reset = 1'b1; capture = 1'b1; pc = 32'h200; immExt = 32'h4;
        #1;
        checkVal("rstComb.target", pcTarget, 32'h204);
        clockEdge("rstCap");
        checkVal("rstCap.q.const", pcTargetQ, 32'h0);
        checkVal("rstCap.valid.const", {31'b0, validQ}, 32'd0);
        checkVal("rstComb2.target", pcTarget, 32'h204);
        reset = 1'b0; capture = 1'b0;

        // Randomized traffic, with some small immediates and near-wrap bases
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255)) : $urandom;
            immExt  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            rs1     = $urandom;
            jalrSel = $urandom_range(0, 1) == 1;
            capture = $urandom_range(0, 2) == 0;
            reset   = $urandom_range(0, 15) == 0;
            #1;
            checkComb($sformatf("rnd%0d", i));
            clockEdge($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/pc_target.md
PC_TARGET -- requirements
Module: pcTarget

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width; only 32 is required to be supported.
REQ-002 SHALL have parameter ALIGN_CHECK, default 1, which enables the misalignment flag (1 = enabled, 0 = flag tied 0).
REQ-003 SHALL have port clk, input, 1, the single clock; all registered state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port pc, input, XLEN, the current instruction address.
REQ-006 SHALL have port immExt, input, XLEN, the sign-extended immediate, two's complement.
REQ-007 SHALL have port rs1, input, XLEN, the JALR base register value; declared default 0.
REQ-008 SHALL have port jalrSel, input, 1, which selects rs1 as the base and enables LSB clearing; declared default 0.
REQ-009 SHALL have port capture, input, 1, which loads the registered copy; declared default 0.
REQ-010 SHALL have port pcTarget, output, XLEN, the combinational branch/jump target.
REQ-011 SHALL have port carry, output, 1, the combinational carry-out of the addition (address wrap).
REQ-012 SHALL have port misaligned, output, 1, combinational; set when the target is not 4-byte aligned.
REQ-013 SHALL have port pcTargetQ, output, XLEN, the registered target.
REQ-014 SHALL have port validQ, output, 1, set when pcTargetQ holds a captured value.

Function
REQ-015 SHALL compute sum = base + immExt modulo 2^XLEN, with base = pc when jalrSel=0 and base = rs1 when jalrSel=1.
REQ-016 SHALL drive pcTarget = sum when jalrSel=0, and sum with bit 0 forced to 0 when jalrSel=1.
REQ-017 SHALL make pcTarget, carry and misaligned purely combinational, with zero latency, and independent of clk/reset, so that correct values appear with clk floating.
REQ-018 SHALL drive carry = bit XLEN of the unsigned (XLEN+1)-bit sum base+immExt.
REQ-019 SHALL report the wrapped result on pcTarget and SHALL NOT saturate when wrap occurs.
REQ-020 SHALL drive misaligned = (pcTarget[1:0] != 0) when ALIGN_CHECK=1, and 0 otherwise.
REQ-021 SHALL load pcTargetQ <= pcTarget and set validQ <= 1 on a rising clk edge with capture=1 and reset=0.
REQ-022 SHALL hold pcTargetQ and validQ unchanged when capture=0.
REQ-023 SHALL let reset win when reset and capture are asserted in the same cycle.
REQ-024 SHALL NOT propagate X from an undriven rs1 into pcTarget when jalrSel=0.

Reset
REQ-025 SHALL clear pcTargetQ to 0 and validQ to 0 on a rising clk edge with reset=1.
REQ-026 SHALL leave combinational outputs unaffected by reset; they track the inputs during reset.
REQ-027 SHALL discard a capture in progress when reset is asserted mid-operation; validQ reads 0 in the cycle after.

Structure
REQ-028 SHALL place the XLEN default and the alignment mask constant (2'b00) in the shared processor package.
REQ-029 SHALL implement the design as a single flat module; the adder is inline with no sub-module, and an optional sub-module pcTargetReg may hold the capture register.

Verification
REQ-030 SHALL cover: pc=4, immExt=4, jalrSel=0 -> pcTarget=0x00000008, carry=0, misaligned=0.
REQ-031 SHALL cover: pc=12, immExt=10 -> pcTarget=0x00000016, misaligned=1, carry=0.
REQ-032 SHALL cover: pc=0xFFFFFFFC, immExt=8 -> pcTarget=0x00000004, carry=1; and pc=0x100, immExt=0xFFFFFFF0 -> pcTarget=0x000000F0, carry=1.
REQ-033 SHALL cover: rs1=0x1001, immExt=2, jalrSel=1 -> pcTarget=0x00001002, with bit 0 cleared from 0x1003.
REQ-034 SHALL cover: capture=1 for one edge with pc=0x40, immExt=0x20 -> pcTargetQ=0x60 and validQ=1; then capture=0 with changed inputs -> pcTargetQ stays 0x60.
REQ-035 SHALL cover: reset=1 together with capture=1 -> after the edge pcTargetQ=0 and validQ=0, while pcTarget still tracks the inputs.
